// File: rtl/adc5g_autoconfig_seq_pkg.sv
// Shared definitions for the ADC5G power-up configuration sequencer:
// FSM encoding, ADC5G register map and the fixed register-write table.
package adc5g_autoconfig_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWRWAIT  = 3'd1,
    S_ISSUE    = 3'd2,
    S_ACKWAIT  = 3'd3,
    S_BUSYWAIT = 3'd4,
    S_NEXT     = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } seq_state_e;

  localparam int TMR_W = 10;

  localparam logic [3:0] ADC5G_REG_NOP      = 4'h0;
  localparam logic [3:0] ADC5G_REG_CTRL     = 4'h1;
  localparam logic [3:0] ADC5G_REG_CHSEL    = 4'h2;
  localparam logic [3:0] ADC5G_REG_OFFSET   = 4'h3;
  localparam logic [3:0] ADC5G_REG_GAIN     = 4'h4;
  localparam logic [3:0] ADC5G_REG_PHASE    = 4'h5;
  localparam logic [3:0] ADC5G_REG_FISDA    = 4'h6;
  localparam logic [3:0] ADC5G_REG_TESTMODE = 4'h7;
  localparam logic [3:0] ADC5G_REG_CALCTRL  = 4'h9;

  localparam logic [15:0] ADC5G_CTRL_BASE = 16'h7CB4;
  localparam logic [15:0] ADC5G_CTRL_ILV  = 16'h0008;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } cfg_entry_t;

  // Only the control word depends on the interleave mode.
  function automatic cfg_entry_t adc5g_cfg_entry(input logic [3:0] idx, input logic interleaved);
    cfg_entry_t e;
    case (idx)
      4'd0:    e = '{ADC5G_REG_CTRL, interleaved ? (ADC5G_CTRL_BASE | ADC5G_CTRL_ILV) : ADC5G_CTRL_BASE};
      4'd1:    e = '{ADC5G_REG_CHSEL,    16'h0081};
      4'd2:    e = '{ADC5G_REG_OFFSET,   16'h0082};
      4'd3:    e = '{ADC5G_REG_GAIN,     16'h0083};
      4'd4:    e = '{ADC5G_REG_PHASE,    16'h0084};
      4'd5:    e = '{ADC5G_REG_FISDA,    16'h0085};
      4'd6:    e = '{ADC5G_REG_TESTMODE, 16'h0086};
      4'd7:    e = '{ADC5G_REG_CALCTRL,  16'h0001};
      default: e = '{ADC5G_REG_NOP,      16'h0000};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/adc5g_autoconfig_seq_if.sv
// 3-wire serializer config port: sequencer is master, serializer is slave.
interface adc5g_autoconfig_seq_if;
  logic        cfg_start;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_done;

  modport master (output cfg_start, cfg_addr, cfg_data, input cfg_done);
  modport slave  (input cfg_start, cfg_addr, cfg_data, output cfg_done);
endinterface

// File: rtl/adc5g_autoconfig_seq_timer.sv
// Loadable saturating down-counter; expired_o is high while the count is zero.
module adc5g_seq_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/adc5g_autoconfig_seq.sv
// ADC5G power-up configuration sequencer: walks the fixed register table and
// hands each write to the 3-wire serializer, reporting done or timeout error.
module adc5g_autoconfig_seq #(
  parameter int NUM_ENTRIES  = 8,
  parameter bit INTERLEAVED  = 1'b0,
  parameter int PWRUP_WAIT   = 255,
  parameter int ACK_TIMEOUT  = 7,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst_n,
  input  logic                           auto_en,
  input  logic                           trigger,
  input  logic                           adc_reset,
  adc5g_autoconfig_seq_if.master         cfg,
  output logic                           cfg_own,
  output logic                           seq_busy,
  output logic                           seq_done,
  output logic                           seq_err,
  output logic [3:0]                     err_idx
);
  import adc5g_autoconfig_seq_pkg::*;

  seq_state_e        state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              arst_prev_q;
  logic              start_q, start_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [3:0]        err_idx_q, err_idx_d;
  logic              tmr_load, tmr_exp;
  logic [TMR_W-1:0]  tmr_val;
  logic              run_req, busy;

  assign busy    = state_q inside {S_PWRWAIT, S_ISSUE, S_ACKWAIT, S_BUSYWAIT, S_NEXT};
  assign run_req = (trigger & ~adc_reset) | (auto_en & arst_prev_q & ~adc_reset);

  adc5g_seq_timer #(.W(TMR_W)) u_tmr (
    .clk       (OPB_Clk),
    .rst_n     (OPB_Rst_n),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    start_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (adc_reset && busy) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (run_req) begin
          state_d  = S_PWRWAIT;
          done_d   = 1'b0;
          err_d    = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PWRUP_WAIT);
        end
        S_PWRWAIT: if (tmr_exp && cfg.cfg_done) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end
        S_ISSUE: begin
          state_d  = S_ACKWAIT;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ACK_TIMEOUT);
        end
        S_ACKWAIT: begin
          // A done-fall on the expiry cycle still counts as an acknowledge.
          if (!cfg.cfg_done) begin
            state_d  = S_BUSYWAIT;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(DONE_TIMEOUT);
          end else if (tmr_exp) begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end
        S_BUSYWAIT: begin
          if (cfg.cfg_done) begin
            state_d = S_NEXT;
          end else if (tmr_exp) begin
            state_d   = S_ERROR;
            err_d     = 1'b1;
            err_idx_d = idx_q;
          end
        end
        S_NEXT: begin
          if (idx_q == 4'(NUM_ENTRIES - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ISSUE;
            start_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Address/data are captured on ISSUE entry and held until the next write.
    if (start_d) {addr_d, data_d} = adc5g_cfg_entry(idx_d, INTERLEAVED);
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      arst_prev_q <= 1'b0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arst_prev_q <= adc_reset;
      start_q     <= start_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_idx_q   <= err_idx_d;
    end
  end

  // An abort landing on the ISSUE cycle must not reach the serializer.
  assign cfg.cfg_start = start_q & ~adc_reset;
  assign cfg.cfg_addr  = addr_q;
  assign cfg.cfg_data  = data_q;
  assign seq_busy      = busy;
  assign cfg_own       = busy;
  assign seq_done      = done_q;
  assign seq_err       = err_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_adc5g_autoconfig_seq.sv
// Bench for adc5g_autoconfig_seq: directed runs against a serializer model,
// with a scoreboard queue of expected writes checked by a start monitor.
module tb_adc5g_autoconfig_seq;

  localparam int P    = 255;
  localparam int A    = 7;
  localparam int D    = 1023;
  localparam int BUSY = 544;
  localparam int LAT  = 2;
  localparam int STICK_N = 3;
  localparam int SER_OFF = 0, SER_NORMAL = 1, SER_NOACK = 2, SER_STUCK = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic auto_en = 1'b0, trigger = 1'b0, adc_reset = 1'b1, il_trig = 1'b0;
  logic cfg_own, seq_busy, seq_done, seq_err;
  logic [3:0] err_idx;
  logic il_own, il_busy, il_done, il_err;
  logic [3:0] il_err_idx;

  adc5g_autoconfig_seq_if cbus ();
  adc5g_autoconfig_seq_if il_bus ();

  always #5 clk = ~clk;

  adc5g_autoconfig_seq dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .auto_en(auto_en), .trigger(trigger),
    .adc_reset(adc_reset), .cfg(cbus), .cfg_own(cfg_own), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_err(seq_err), .err_idx(err_idx)
  );

  adc5g_autoconfig_seq #(.INTERLEAVED(1'b1)) dut_il (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .auto_en(1'b0), .trigger(il_trig),
    .adc_reset(1'b0), .cfg(il_bus), .cfg_own(il_own), .seq_busy(il_busy),
    .seq_done(il_done), .seq_err(il_err), .err_idx(il_err_idx)
  );

  // Expected {addr, data} table, written out by hand.
  logic [19:0] tbl [8] = '{20'h17CB4, 20'h20081, 20'h30082, 20'h40083,
                           20'h50084, 20'h60085, 20'h70086, 20'h90001};
  logic [19:0] il_ctrl = 20'h17CBC;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  logic [19:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Serializer model: done falls LAT cycles after start, stays low BUSY cycles.
  int ser_mode = SER_OFF;
  int ser_dly = 0, ser_busy = 0, ser_n = 0, ser_fall_cyc = 0;
  bit ser_stuck = 1'b0;

  always @(negedge clk) begin
    if (ser_mode == SER_OFF) begin
      ser_dly <= 0; ser_busy <= 0; ser_n <= 0; ser_stuck <= 1'b0;
      cbus.cfg_done <= 1'b1;
    end else if (cbus.cfg_start && ser_mode != SER_NOACK) begin
      ser_dly   <= LAT;
      ser_stuck <= (ser_mode == SER_STUCK) && (ser_n == STICK_N);
      ser_n     <= ser_n + 1;
    end else if (ser_dly > 0) begin
      ser_dly <= ser_dly - 1;
      if (ser_dly == 1) begin
        cbus.cfg_done <= 1'b0;
        ser_busy      <= BUSY;
        ser_fall_cyc  <= cyc;
      end
    end else if (ser_busy > 0 && !ser_stuck) begin
      ser_busy <= ser_busy - 1;
      if (ser_busy == 1) cbus.cfg_done <= 1'b1;
    end
  end

  // Monitor: every start pops one expected write; no back-to-back starts.
  int n_starts = 0, last_start_cyc = 0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (cbus.cfg_start === 1'b1) begin
      n_starts       <= n_starts + 1;
      last_start_cyc <= cyc;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_start: got addr 0x%0h data 0x%0h with empty queue", cbus.cfg_addr, cbus.cfg_data);
      end else begin
        chk("start_write", {prev_start, cbus.cfg_addr, cbus.cfg_data}, {1'b0, exp_q.pop_front()});
      end
    end
    prev_start <= cbus.cfg_start;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_run();
    for (int i = 0; i < 8; i++) exp_q.push_back(tbl[i]);
  endtask

  task automatic pulse_trig();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic wait_starts(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (n_starts >= k) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (seq_done) ok = 1'b1;
    end
  endtask

  task automatic wait_err(input int budget, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (seq_err) begin ok = 1'b1; at = cyc; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, t_fall, s, at;
    il_bus.cfg_done = 1'b1;

    // Reset state
    tick(3);
    chk("reset_outputs", {cbus.cfg_start, cbus.cfg_addr, cbus.cfg_data, cfg_own,
                          seq_busy, seq_done, seq_err, err_idx}, '0);
    rst_n = 1'b1;
    auto_en = 1'b1;
    tick(3);

    // T1: auto run on adc_reset fall; t_fall is the first edge sampling it low
    ser_mode = SER_NORMAL;
    push_run();
    base = n_starts;
    @(negedge clk) adc_reset = 1'b0;
    t_fall = cyc + 1;
    wait_starts(base + 1, 400, ok);
    chk("t1_first_start_seen", ok, 1);
    chk("t1_first_start_cyc", last_start_cyc, t_fall + P + 1);
    chk("t1_own_busy_running", {cfg_own, seq_busy}, 2'b11);
    wait_done(6000, ok);
    chk("t1_seq_done", ok, 1);
    chk("t1_start_count", n_starts - base, 8);
    chk("t1_own_after_done", {cfg_own, seq_busy, seq_err}, 3'b000);
    chk("t1_queue_drained", exp_q.size(), 0);

    // T2: serializer never acknowledges
    ser_mode = SER_NOACK;
    push_run();
    base = n_starts;
    pulse_trig();
    tick(2);
    chk("t2_done_cleared", seq_done, 0);
    wait_starts(base + 1, 400, ok);
    chk("t2_first_start_seen", ok, 1);
    s = last_start_cyc;
    wait_err(100, ok, at);
    chk("t2_err_cycle", at, s + A + 2);
    chk("t2_err_idx", err_idx, 0);
    tick(50);
    chk("t2_no_more_starts", n_starts - base, 1);
    chk("t2_own_after_err", cfg_own, 0);
    exp_q.delete();

    // T3: done stuck low on write 3
    ser_mode = SER_OFF;
    tick(2);
    ser_mode = SER_STUCK;
    push_run();
    base = n_starts;
    pulse_trig();
    tick(2);
    chk("t3_err_cleared", seq_err, 0);
    wait_err(4000, ok, at);
    chk("t3_err_seen", ok, 1);
    chk("t3_err_cycle", at, (ser_fall_cyc + 1) + D + 1);
    chk("t3_err_idx", err_idx, 3);
    chk("t3_start_count", n_starts - base, 4);
    exp_q.delete();

    // T4: adc_reset pulse during write 5 aborts, fall restarts from idx 0
    ser_mode = SER_OFF;
    tick(2);
    ser_mode = SER_NORMAL;
    push_run();
    base = n_starts;
    pulse_trig();
    wait_starts(base + 6, 4000, ok);
    chk("t4_reached_write5", ok, 1);
    tick(10);
    exp_q.delete();
    @(negedge clk) adc_reset = 1'b1;
    @(negedge clk);
    chk("t4_abort_own", {cfg_own, seq_busy}, 2'b00);
    chk("t4_abort_flags", {seq_done, seq_err}, 2'b00);
    tick(5);
    push_run();
    base = n_starts;
    @(negedge clk) adc_reset = 1'b0;
    wait_done(7000, ok);
    chk("t4_restart_done", ok, 1);
    chk("t4_restart_starts", n_starts - base, 8);
    chk("t4_queue_drained", exp_q.size(), 0);

    // T5: triggers while busy are ignored; trigger from DONE reruns
    push_run();
    base = n_starts;
    pulse_trig();
    tick(3);
    chk("t5_done_cleared", seq_done, 0);
    pulse_trig();
    wait_starts(base + 3, 2000, ok);
    tick(100);
    pulse_trig();
    wait_done(6000, ok);
    chk("t5_done", ok, 1);
    chk("t5_start_count", n_starts - base, 8);

    // T5b: trigger and adc_reset fall in the same cycle give a single run
    @(negedge clk) adc_reset = 1'b1;
    tick(4);
    push_run();
    base = n_starts;
    @(negedge clk) begin adc_reset = 1'b0; trigger = 1'b1; end
    @(negedge clk) trigger = 1'b0;
    wait_done(6000, ok);
    chk("t5b_done", ok, 1);
    chk("t5b_start_count", n_starts - base, 8);
    chk("t5b_queue_drained", exp_q.size(), 0);

    // T6: async reset mid-BUSYWAIT clears outputs before the next edge
    push_run();
    base = n_starts;
    pulse_trig();
    wait_starts(base + 2, 2000, ok);
    tick(20);
    chk("t6_busy_before_reset", seq_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs", {cbus.cfg_start, cbus.cfg_addr, cbus.cfg_data, cfg_own,
                                   seq_busy, seq_done, seq_err, err_idx}, '0);
    exp_q.delete();
    ser_mode = SER_OFF;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // T6: interleaved build issues a different control word first
    @(negedge clk) il_trig = 1'b1;
    @(negedge clk) il_trig = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (il_bus.cfg_start) ok = 1'b1;
    end
    chk("t6_il_start_seen", ok, 1);
    chk("t6_il_ctrl_entry", {il_bus.cfg_addr, il_bus.cfg_data}, il_ctrl);

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
